// File: rtl/clock_division_detector_pkg.sv
// -----------------------------------------------------------------------------
// clock_division_detector_pkg
// Shared definitions for the clock division detector:
//   - FSM state encoding (IDLE / MEASURE / LOCKED / LOST)
//   - pmax_f      : longest representable period for a given code width/mode
//   - cnt_width_f : width of the period counter (must hold PMAX+1)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package clock_division_detector_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_MEASURE = 2'd1;
  localparam state_t ST_LOCKED  = 2'd2;
  localparam state_t ST_LOST    = 2'd3;

  // Linear mode: P = code+1, so the largest code (2**w - 1) gives P = 2**w.
  // Power-of-two mode: P = 2**code, largest code (2**w - 1) gives 2**(2**w - 1).
  // Power-of-two mode is only meaningful for w <= 5 with a 32-bit result.
  function automatic int pmax_f(input int w, input int p2);
    if (p2 != 0) return 1 << ((1 << w) - 1);
    else         return 1 << w;
  endfunction

  // The counter saturates at PMAX+1, so it needs to represent PMAX+1.
  function automatic int cnt_width_f(input int w, input int p2);
    return $clog2(pmax_f(w, p2) + 2);
  endfunction

endpackage

// File: rtl/clock_division_detector_if.sv
// -----------------------------------------------------------------------------
// clock_division_detector_if
// Groups the measured signal and the detector's result/status outputs.
//   signal_in : divided clock being measured (source -> detector)
//   division  : recovered division code      (detector -> observer)
//   valid     : division is locked and current
//   error     : one-cycle pulse on an unrepresentable period
//   lost      : no rising edge within the timeout
// Modports: master = stimulus/observer side, slave = detector side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface clock_division_detector_if #(
  parameter int DIVISION_WIDTH = 4
);
  logic                      signal_in;
  logic [DIVISION_WIDTH-1:0] division;
  logic                      valid;
  logic                      error;
  logic                      lost;

  modport master (output signal_in, input division, valid, error, lost);
  modport slave  (input signal_in, output division, valid, error, lost);
endinterface

// File: rtl/clock_division_detector_sync.sv
// -----------------------------------------------------------------------------
// clock_division_detector_sync
// STAGES-deep flop chain that brings an asynchronous input into the clock_in
// domain.
//   clock_in : destination clock
//   resetn   : asynchronous active-low reset, chain clears to 0
//   d        : asynchronous input
//   q        : synchronized output (STAGES cycles of latency)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module clock_division_detector_sync #(
  parameter int STAGES = 2
) (
  input  logic clock_in,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbour; blocking here would
  // collapse the chain into a single stage.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clock_division_detector.sv
// -----------------------------------------------------------------------------
// clock_division_detector
// Measures the period of a slow periodic signal in clock_in cycles between its
// rising edges and reports the division code that would reproduce it.
//   clock_in : reference clock, all logic on posedge
//   resetn   : asynchronous active-low reset
//   bus      : slave side of clock_division_detector_if
//              (signal_in in; division, valid, error, lost out)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module clock_division_detector
  import clock_division_detector_pkg::*;
#(
  parameter int DIVISION_WIDTH = 4,
  parameter int POWER_OF_TWO   = 0,
  parameter int STAGES         = 2,
  parameter int LOCK_COUNT     = 2
) (
  input  logic                     clock_in,
  input  logic                     resetn,
  clock_division_detector_if.slave bus
);

  localparam int DW   = DIVISION_WIDTH;
  localparam int PMAX = pmax_f(DIVISION_WIDTH, POWER_OF_TWO);
  localparam int CW   = cnt_width_f(DIVISION_WIDTH, POWER_OF_TWO);
  localparam int LW   = $clog2(LOCK_COUNT + 1);

  localparam logic [CW-1:0] P_ONE  = CW'(1);
  localparam logic [CW-1:0] P_TWO  = CW'(2);
  localparam logic [CW-1:0] P_MAX  = CW'(PMAX);
  localparam logic [CW-1:0] P_SAT  = CW'(PMAX + 1);
  localparam logic [LW-1:0] L_LOCK = LW'(LOCK_COUNT);

  // ---------------------------------------------------------------------------
  // Synchronizer and rising-edge detect
  // ---------------------------------------------------------------------------
  logic sig_sync;
  logic sig_dly_q, sig_dly_d;
  logic rise;

  clock_division_detector_sync #(.STAGES(STAGES)) u_sync (
    .clock_in (clock_in),
    .resetn   (resetn),
    .d        (bus.signal_in),
    .q        (sig_sync)
  );

  assign sig_dly_d = sig_sync;
  assign rise      = sig_sync & ~sig_dly_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_q,    state_d;
  logic [CW-1:0]   period_q,   period_d;   // cycles since last edge
  logic [CW-1:0]   prev_q,     prev_d;     // last accepted period (0 = none)
  logic [LW-1:0]   lock_q,     lock_d;
  logic [DW-1:0]   division_q, division_d;
  logic            valid_q,    valid_d;
  logic            error_q,    error_d;
  logic            lost_q,     lost_d;

  // ---------------------------------------------------------------------------
  // Code conversion of the period that just ended (period_q at an edge)
  // ---------------------------------------------------------------------------
  logic          code_ok;
  logic [DW-1:0] code;

  // NOTE: every variable assigned in an always_comb gets a default at the top
  // so no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    code_ok = 1'b0;
    code    = '0;
    if (POWER_OF_TWO != 0) begin
      // One-hot check plus priority encode: the highest set bit is log2(P).
      code_ok = (period_q >= P_TWO) && (period_q <= P_MAX) &&
                ((period_q & (period_q - P_ONE)) == '0);
      for (int i = 0; i < CW; i++) begin
        if (period_q[i]) code = DW'(i);
      end
    end else begin
      code_ok = (period_q >= P_TWO) && (period_q <= P_MAX);
      code    = DW'(period_q - P_ONE);
    end
  end

  // ---------------------------------------------------------------------------
  // Period counter, lock tracking and FSM
  // ---------------------------------------------------------------------------
  logic [LW-1:0] lock_nxt;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    lock_d     = lock_q;
    division_d = division_q;
    valid_d    = valid_q;
    error_d    = 1'b0;
    lost_d     = lost_q;
    lock_nxt   = '0;

    if (rise)                period_d = P_ONE;
    else if (period_q == P_SAT) period_d = period_q;
    else                     period_d = period_q + P_ONE;

    if (rise) begin
      if (state_q == ST_IDLE) begin
        // First edge only starts the measurement; no period exists yet.
        state_d = ST_MEASURE;
        lock_d  = '0;
        prev_d  = '0;
      end else begin
        lost_d = 1'b0;
        if (!code_ok) begin
          // Also covers the first edge after LOST: the counter is saturated,
          // so that period is always rejected and measurement restarts.
          state_d = ST_MEASURE;
          error_d = 1'b1;
          valid_d = 1'b0;
          lock_d  = '0;
          prev_d  = '0;
        end else if (state_q == ST_LOCKED) begin
          if (period_q != prev_q) begin
            // Division keeps the last locked value while re-measuring.
            state_d = ST_MEASURE;
            valid_d = 1'b0;
            lock_d  = LW'(1);
            prev_d  = period_q;
          end
        end else begin
          lock_nxt = (period_q == prev_q) ? lock_q + LW'(1) : LW'(1);
          state_d  = ST_MEASURE;
          prev_d   = period_q;
          lock_d   = lock_nxt;
          if (lock_nxt >= L_LOCK) begin
            state_d    = ST_LOCKED;
            division_d = code;
            valid_d    = 1'b1;
          end
        end
      end
    end else if (period_q == P_SAT && state_q != ST_LOST) begin
      // Timeout only when no edge arrives this cycle; a coincident edge wins.
      state_d = ST_LOST;
      lost_d  = 1'b1;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      sig_dly_q  <= 1'b0;
      state_q    <= ST_IDLE;
      period_q   <= '0;
      prev_q     <= '0;
      lock_q     <= '0;
      division_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      sig_dly_q  <= sig_dly_d;
      state_q    <= state_d;
      period_q   <= period_d;
      prev_q     <= prev_d;
      lock_q     <= lock_d;
      division_q <= division_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      lost_q     <= lost_d;
    end
  end

  assign bus.division = division_q;
  assign bus.valid    = valid_q;
  assign bus.error    = error_q;
  assign bus.lost     = lost_q;

endmodule
